lbdr_dr: RTL and testbench
==========================

# lbdr_dr

Parametrised LBDR routing unit for one router input port. It computes the output-port one-hot vector from a header flit's destination, using configurable routing bits (Rxy), connectivity bits (Cx) and deroute bits (DR). The port selection is held for the whole packet and released after the tail. It sits between the input FIFO and the allocator. It extends minimal LBDR with a mesh-size parameter, deroute fallback, a packet-tracking FSM, runtime configuration writes, error reporting and a routed-packet counter.

## Interface
- COORD_W, 2: bits per X/Y coordinate; address width is 2*COORD_W, {y,x}
- CNT_W, 16: width of routed-packet counter
- RXY_RST, 8'h3C: Rxy reset value
- CX_RST, 4'hF: Cx reset value {S,W,E,N}
- DR_RST, 8'h00: deroute reset value
- CUR_RST, 5: own address reset value
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- empty  in  1  input FIFO empty; a flit is accepted on any cycle with empty=0
- flit_id  in  3  flit type: HEADER=3'b001, BODY=3'b010, TAIL=3'b100 (shared parameters include)
- dst_addr  in  2*COORD_W  destination, valid with a header
- cfg_we  in  1  configuration write strobe
- cfg_rxy  in  8  new Rxy
- cfg_cx  in  4  new Cx
- cfg_dr  in  8  new DR
- cfg_cur  in  2*COORD_W  new own address
- Nport, Eport, Wport, Sport, Lport  out  1 each  selected output port, registered
- route_err  out  1  one-cycle pulse on unroutable header or protocol violation
- pkt_cnt  out  CNT_W  count of successfully routed headers, saturating

## Operation
- Config registers Rxy, Cx, DR and cur are loaded from the *_RST parameters on reset.
  - cfg_we writes all four on the next edge, but only in state IDLE; writes are ignored in HOLD.
  - If cfg_we and a header arrive together in IDLE, the header routes with the old config and the config updates on the same edge.
- Comparators, all unsigned: N1 = y_dst<y_cur; S1 = y_cur<y_dst; E1 = x_cur<x_dst; W1 = x_dst<x_cur.
- Rxy bits are Rne, Rnw, Ren, Res, Rwn, Rws, Rse, Rsw, at bits [0] through [7].
- Minimal routing:
  - N = (N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw)&Cn
  - E = (E1&~N1&~S1 | E1&N1&Ren | E1&S1&Res)&Ce
  - W = (W1&~N1&~S1 | W1&N1&Rwn | W1&S1&Rws)&Cw
  - S = (S1&~E1&~W1 | S1&E1&Rse | S1&W1&Rsw)&Cs
  - L = ~N1&~E1&~W1&~S1
- Deroute applies when the minimal vector is all zero and L=0.
  - Primary direction P is chosen by priority N1, then S1, then E1, then W1; index i is N=0, E=1, W=2, S=3.
  - Alternative port = DR[2i+1:2i], coded 0=N, 1=E, 2=W, 3=S.
  - The alternative is taken only if its C bit is 1 and it is not P. Otherwise the header is unroutable: route_err pulses and all ports are 0.
- FSM, two states:
  - IDLE: an accepted HEADER registers the port vector and moves to HOLD. pkt_cnt increments unless the header was unroutable.
  - IDLE: an accepted BODY or TAIL is dropped; route_err pulses and ports stay 0.
  - HOLD: an accepted BODY changes nothing.
  - HOLD: an accepted TAIL clears ports and moves to IDLE.
  - HOLD: an accepted HEADER pulses route_err, is routed as a new packet, and the FSM stays in HOLD.
  - Cycles with empty=1 change nothing. Ports are held, not cleared. An illegal flit_id is treated as BODY.
- pkt_cnt saturates at all-ones.

## Timing
- Reset, asynchronous: all ports 0, route_err 0, pkt_cnt 0, state IDLE, config = parameters. Reset mid-packet drops the packet immediately.
- Header accepted at edge k: ports valid after edge k, latency 1 cycle. pkt_cnt updates at the same edge.
- Tail accepted at edge t: ports 0 after edge t.
- route_err is high for exactly the cycle after the offending flit's edge.
- Back-to-back tail then header on consecutive cycles: ports go 0 for one cycle, then show the new vector.

## Test plan
- Base config: cur=5 (x=1, y=1), Rxy=3C, Cx=F.
- Header dst=1 -> Nport=1 one cycle later. Body plus two empty cycles -> Nport held. Tail -> all 0; pkt_cnt=1.
- Header dst=0 (N1&W1, Rnw=0, Rwn=1) -> Wport. Header dst=8 (S1&W1, Rsw=0, Rws=1) -> Wport. Header dst=5 -> Lport.
- cfg_we with Cx=E, DR=8'h01, then header dst=1 -> Eport (deroute). Repeat with DR=8'h00 -> route_err pulse, ports 0, pkt_cnt unchanged.
- BODY in IDLE -> route_err, ports 0. HEADER in HOLD -> route_err and ports switch to the new route. cfg_we in HOLD -> config unchanged.
- Assert rst mid-packet with Sport=1 -> Sport=0 without waiting for a clock; the next header routes from the parameter config.
- CNT_W=2: route 5 packets -> pkt_cnt=3 (saturated).

Source files
------------

// File: rtl/lbdr_dr.sv
// LBDR routing unit for one router input port.
// Routes header flits from Rxy/Cx/DR config bits, holds the selected output
// port for the whole packet, and counts successfully routed headers.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no packet open; ports 0; config writes accepted
// ST_HOLD | packet open; port vector held until the tail flit
module lbdr_dr #(
   parameter int         COORD_W = 2,
   parameter int         CNT_W   = 16,
   parameter logic [7:0] RXY_RST = 8'h3C,
   parameter logic [3:0] CX_RST  = 4'hF,
   parameter logic [7:0] DR_RST  = 8'h00,
   parameter int         CUR_RST = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 empty,
   input  logic [2:0]           flit_id,
   input  logic [2*COORD_W-1:0] dst_addr,
   input  logic                 cfg_we,
   input  logic [7:0]           cfg_rxy,
   input  logic [3:0]           cfg_cx,
   input  logic [7:0]           cfg_dr,
   input  logic [2*COORD_W-1:0] cfg_cur,
   output logic                 Nport,
   output logic                 Eport,
   output logic                 Wport,
   output logic                 Sport,
   output logic                 Lport,
   output logic                 route_err,
   output logic [CNT_W-1:0]     pkt_cnt
);

   localparam int AW = 2 * COORD_W;
   localparam logic [AW-1:0] CUR_INIT = AW'(CUR_RST);

   localparam logic [2:0] FLIT_HEADER = 3'b001;
   localparam logic [2:0] FLIT_TAIL   = 3'b100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       rxy_q, rxy_d;
   logic [3:0]       cx_q, cx_d;
   logic [7:0]       dr_q, dr_d;
   logic [AW-1:0]    cur_q, cur_d;
   logic [4:0]       port_q, port_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
   logic               n1, s1, e1, w1;
   logic [3:0]         min_vec;
   logic               l_hit;
   logic [1:0]         pri_dir, alt_dir;
   logic               alt_ok;
   logic [4:0]         route_vec;
   logic               unroutable;
   logic               accept, is_hdr, is_tail;

   assign x_cur = cur_q[COORD_W-1:0];
   assign y_cur = cur_q[AW-1:COORD_W];
   assign x_dst = dst_addr[COORD_W-1:0];
   assign y_dst = dst_addr[AW-1:COORD_W];

   assign n1 = (y_dst < y_cur);
   assign s1 = (y_cur < y_dst);
   assign e1 = (x_cur < x_dst);
   assign w1 = (x_dst < x_cur);

   // Minimal LBDR port equations; bit order {S,W,E,N} matches Cx.
   assign min_vec[0] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_q[0]) | (n1 & w1 & rxy_q[1])) & cx_q[0];
   assign min_vec[1] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_q[2]) | (e1 & s1 & rxy_q[3])) & cx_q[1];
   assign min_vec[2] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_q[4]) | (w1 & s1 & rxy_q[5])) & cx_q[2];
   assign min_vec[3] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_q[6]) | (s1 & w1 & rxy_q[7])) & cx_q[3];
   assign l_hit      = ~n1 & ~e1 & ~w1 & ~s1;

   // Deroute primary direction priority is N, S, E, W; codes are N=0 E=1 W=2 S=3.
   assign pri_dir = n1 ? 2'd0 : (s1 ? 2'd3 : (e1 ? 2'd1 : 2'd2));
   assign alt_dir = dr_q[{pri_dir, 1'b0} +: 2];
   assign alt_ok  = cx_q[alt_dir] & (alt_dir != pri_dir);

   // Final port vector {L,S,W,E,N}: minimal result, else deroute, else unroutable.
   always_comb begin
      route_vec  = {l_hit, min_vec};
      unroutable = 1'b0;
      if ((min_vec == 4'd0) && !l_hit) begin
         route_vec = 5'd0;
         if (alt_ok) begin
            route_vec[alt_dir] = 1'b1;
         end else begin
            unroutable = 1'b1;
         end
      end
   end

   assign accept  = ~empty;
   assign is_hdr  = (flit_id == FLIT_HEADER);
   assign is_tail = (flit_id == FLIT_TAIL);

   // Packet-tracking FSM, config write path, error pulse and routed-packet counter.
   always_comb begin
      state_d = state_q;
      rxy_d   = rxy_q;
      cx_d    = cx_q;
      dr_d    = dr_q;
      cur_d   = cur_q;
      port_d  = port_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_hdr) begin
                  port_d  = route_vec;
                  state_d = ST_HOLD;
                  err_d   = unroutable;
                  if (!unroutable && (cnt_q != {CNT_W{1'b1}})) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            // Routing above already used the old config; the new one lands on the same edge.
            if (cfg_we) begin
               rxy_d = cfg_rxy;
               cx_d  = cfg_cx;
               dr_d  = cfg_dr;
               cur_d = cfg_cur;
            end
         end
         ST_HOLD: begin
            if (accept) begin
               if (is_hdr) begin
                  port_d = route_vec;
                  err_d  = 1'b1;
                  if (!unroutable && (cnt_q != {CNT_W{1'b1}})) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else if (is_tail) begin
                  port_d  = 5'd0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            port_d  = 5'd0;
         end
      endcase
   end

   // State and config registers with asynchronous reset to parameter values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rxy_q   <= RXY_RST;
         cx_q    <= CX_RST;
         dr_q    <= DR_RST;
         cur_q   <= CUR_INIT;
         port_q  <= 5'd0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rxy_q   <= rxy_d;
         cx_q    <= cx_d;
         dr_q    <= dr_d;
         cur_q   <= cur_d;
         port_q  <= port_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Nport     = port_q[0];
   assign Eport     = port_q[1];
   assign Wport     = port_q[2];
   assign Sport     = port_q[3];
   assign Lport     = port_q[4];
   assign route_err = err_q;
   assign pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_lbdr_dr.sv
// Bench for lbdr_dr: directed flits, a behavioural routing model checked every
// cycle, and literal expectations at key points of the sequence.
module tb_lbdr_dr;

   localparam logic [2:0] HDR = 3'b001;
   localparam logic [2:0] BDY = 3'b010;
   localparam logic [2:0] TL  = 3'b100;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       empty = 1'b1;
   logic [2:0] flit_id = 3'b000;
   logic [3:0] dst_addr = 4'd0;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_rxy = 8'h3C;
   logic [3:0] cfg_cx = 4'hF;
   logic [7:0] cfg_dr = 8'h00;
   logic [3:0] cfg_cur = 4'd5;

   logic        n_a, e_a, w_a, s_a, l_a, err_a;
   logic [15:0] cnt_a;
   logic        n_b, e_b, w_b, s_b, l_b, err_b;
   logic [1:0]  cnt_b;

   int total = 0;
   int bad   = 0;

   lbdr_dr #(.COORD_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .empty(empty), .flit_id(flit_id), .dst_addr(dst_addr),
      .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_dr(cfg_dr), .cfg_cur(cfg_cur),
      .Nport(n_a), .Eport(e_a), .Wport(w_a), .Sport(s_a), .Lport(l_a),
      .route_err(err_a), .pkt_cnt(cnt_a)
   );

   lbdr_dr #(.COORD_W(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .empty(empty), .flit_id(flit_id), .dst_addr(dst_addr),
      .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_dr(cfg_dr), .cfg_cur(cfg_cur),
      .Nport(n_b), .Eport(e_b), .Wport(w_b), .Sport(s_b), .Lport(l_b),
      .route_err(err_b), .pkt_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: route by the sign of the coordinate differences. Bit order {L,S,W,E,N}.
   function automatic logic [4:0] mdl_route(input logic [3:0] dst, input logic [3:0] cur,
                                            input logic [7:0] rxy, input logic [3:0] cx,
                                            input logic [7:0] dr, output bit unr);
      int dx, dy, p, alt;
      logic [4:0] v;
      v   = 5'd0;
      unr = 1'b0;
      dx  = int'(dst[1:0]) - int'(cur[1:0]);
      dy  = int'(dst[3:2]) - int'(cur[3:2]);
      if (dx == 0 && dy == 0) return 5'b10000;
      if (dy < 0) v[0] = (dx == 0) || (dx > 0 ? rxy[0] : rxy[1]);
      if (dx > 0) v[1] = (dy == 0) || (dy < 0 ? rxy[2] : rxy[3]);
      if (dx < 0) v[2] = (dy == 0) || (dy < 0 ? rxy[4] : rxy[5]);
      if (dy > 0) v[3] = (dx == 0) || (dx > 0 ? rxy[6] : rxy[7]);
      v[3:0] = v[3:0] & cx;
      if (v == 5'd0) begin
         p   = (dy < 0) ? 0 : (dy > 0) ? 3 : (dx > 0) ? 1 : 2;
         alt = int'(dr[2*p +: 2]);
         if (cx[alt] && alt != p) v[alt] = 1'b1;
         else unr = 1'b1;
      end
      return v;
   endfunction

   logic [4:0] m_ports = 5'd0;
   logic       m_err   = 1'b0;
   int         m_cnt   = 0;
   bit         m_open  = 1'b0;
   logic [7:0] m_rxy = 8'h3C;
   logic [3:0] m_cx  = 4'hF;
   logic [7:0] m_dr  = 8'h00;
   logic [3:0] m_cur = 4'd5;

   // Reference model update, one step per accepted flit.
   always @(posedge clk or posedge rst) begin
      logic [4:0] v;
      bit unr;
      if (rst) begin
         m_ports <= 5'd0; m_err <= 1'b0; m_cnt <= 0; m_open <= 1'b0;
         m_rxy <= 8'h3C; m_cx <= 4'hF; m_dr <= 8'h00; m_cur <= 4'd5;
      end else begin
         m_err <= 1'b0;
         if (!empty) begin
            if (flit_id == HDR) begin
               v = mdl_route(dst_addr, m_cur, m_rxy, m_cx, m_dr, unr);
               m_ports <= v;
               m_open  <= 1'b1;
               m_err   <= unr || m_open;
               if (!unr) m_cnt <= m_cnt + 1;
            end else if (!m_open) begin
               m_err <= 1'b1;
            end else if (flit_id == TL) begin
               m_ports <= 5'd0;
               m_open  <= 1'b0;
            end
         end
         if (cfg_we && !m_open) begin
            m_rxy <= cfg_rxy; m_cx <= cfg_cx; m_dr <= cfg_dr; m_cur <= cfg_cur;
         end
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      check("ports", {27'd0, l_a, s_a, w_a, e_a, n_a}, {27'd0, m_ports});
      check("route_err", {31'd0, err_a}, {31'd0, m_err});
      check("pkt_cnt", {16'd0, cnt_a}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
      check("sat_ports", {27'd0, l_b, s_b, w_b, e_b, n_b}, {27'd0, m_ports});
      check("sat_err", {31'd0, err_b}, {31'd0, m_err});
      check("sat_cnt", {30'd0, cnt_b}, (m_cnt > 3) ? 32'd3 : m_cnt);
   end

   task automatic step(input logic e, input logic [2:0] id, input logic [3:0] d);
      @(posedge clk); #2;
      empty = e; flit_id = id; dst_addr = d; cfg_we = 1'b0;
   endtask

   task automatic nop();
      step(1'b1, 3'b000, 4'd0);
   endtask

   task automatic setcfg(input logic [7:0] rxy, input logic [3:0] cx, input logic [7:0] dr,
                         input logic [3:0] cur);
      @(posedge clk); #2;
      empty = 1'b1; cfg_we = 1'b1;
      cfg_rxy = rxy; cfg_cx = cx; cfg_dr = dr; cfg_cur = cur;
   endtask

   function automatic logic [31:0] ports_a();
      return {27'd0, l_a, s_a, w_a, e_a, n_a};
   endfunction

   initial begin
      #1 rst = 1'b1;
      #11 rst = 1'b0;
      check("rst_ports", ports_a(), 32'h00);
      check("rst_cnt", {16'd0, cnt_a}, 32'd0);

      step(1'b0, HDR, 4'd1); nop();
      check("hdr1_N", ports_a(), 32'h01);
      check("hdr1_cnt", {16'd0, cnt_a}, 32'd1);
      step(1'b0, BDY, 4'd0); nop(); nop();
      check("body_hold_N", ports_a(), 32'h01);
      step(1'b0, TL, 4'd0); nop();
      check("tail_clear", ports_a(), 32'h00);
      check("tail_cnt", {16'd0, cnt_a}, 32'd1);

      step(1'b0, HDR, 4'd0); nop();
      check("dst0_W", ports_a(), 32'h04);
      step(1'b0, TL, 4'd0);
      step(1'b0, HDR, 4'd8); nop();
      check("dst8_W", ports_a(), 32'h04);
      step(1'b0, TL, 4'd0);
      step(1'b0, HDR, 4'd5); nop();
      check("dst5_L", ports_a(), 32'h10);
      step(1'b0, TL, 4'd0);

      setcfg(8'h3C, 4'hE, 8'h01, 4'd5);
      step(1'b0, HDR, 4'd1); nop();
      check("deroute_E", ports_a(), 32'h02);
      check("deroute_cnt", {16'd0, cnt_a}, 32'd5);
      step(1'b0, TL, 4'd0);
      setcfg(8'h3C, 4'hE, 8'h00, 4'd5);
      step(1'b0, HDR, 4'd1); nop();
      check("unroute_err", {31'd0, err_a}, 32'd1);
      check("unroute_ports", ports_a(), 32'h00);
      check("unroute_cnt", {16'd0, cnt_a}, 32'd5);
      nop();
      check("err_one_cycle", {31'd0, err_a}, 32'd0);
      step(1'b0, TL, 4'd0);

      setcfg(8'h3C, 4'hF, 8'h00, 4'd5);
      step(1'b0, BDY, 4'd0); nop();
      check("idle_body_err", {31'd0, err_a}, 32'd1);
      check("idle_body_ports", ports_a(), 32'h00);
      step(1'b0, HDR, 4'd1);
      step(1'b0, HDR, 4'd8); nop();
      check("hold_hdr_err", {31'd0, err_a}, 32'd1);
      check("hold_hdr_W", ports_a(), 32'h04);
      setcfg(8'h00, 4'h0, 8'h00, 4'd0);
      step(1'b0, TL, 4'd0);
      step(1'b0, HDR, 4'd1); nop();
      check("cfg_in_hold_ignored", ports_a(), 32'h01);
      check("sat_cnt_lit", {30'd0, cnt_b}, 32'd3);
      step(1'b0, TL, 4'd0);

      setcfg(8'h3C, 4'hF, 8'h00, 4'd0);
      step(1'b0, HDR, 4'd8); nop();
      check("pre_rst_S", ports_a(), 32'h08);
      #1 rst = 1'b1;
      #1;
      check("async_rst_S", {31'd0, s_a}, 32'd0);
      check("async_rst_cnt", {16'd0, cnt_a}, 32'd0);
      #10 rst = 1'b0;
      step(1'b0, HDR, 4'd1); nop();
      check("post_rst_N", ports_a(), 32'h01);
      check("post_rst_cnt", {16'd0, cnt_a}, 32'd1);
      step(1'b0, TL, 4'd0); nop(); nop();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
